// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone burst master.
//   state_t  : controller states (idle / burst in progress)
//   CTI_*    : Wishbone cycle type identifier encodings
//   BYTE_INC : byte-address step per beat for the default 32-bit bus
//   byte_inc : byte-address step per beat for an arbitrary bus width
//   cti_for  : cycle type for a given beat index within a burst
package wb_master_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned BYTE_INC   = DW_DEFAULT / 8;

  function automatic int unsigned byte_inc(input int unsigned dw);
    return dw / 8;
  endfunction

  // Single-beat commands are classic cycles; bursts are incrementing
  // with the last beat flagged as end-of-burst.
  function automatic logic [2:0] cti_for(input logic [7:0] beat, input logic [7:0] len);
    if (len == 8'd0)     return CTI_CLASSIC;
    else if (beat == len) return CTI_EOB;
    else                 return CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Acknowledge watchdog for the Wishbone burst master.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : restart the count (ack received or no cycle active)
//   en_i         : count this cycle (strobe waiting without ack)
//   expire_o     : high in the cycle the wait reaches TIMEOUT cycles
module wb_ack_timer
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The TIMEOUT-th waiting cycle is the one whose count already holds
  // TIMEOUT-1, so the strobe is dropped after exactly TIMEOUT cycles.
  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone initiator turning command/data streams into classic and
// incrementing-burst cycles toward the SDRAM controller.
//   wb_clk_i, wb_rst_i       : clock, asynchronous active-high reset
//   sdr_init_done            : gates acceptance of new commands
//   cmd_valid/ready/we/addr/len : command stream (len = beats - 1)
//   wdat_valid/ready, wdat   : write-data stream
//   rdat_valid, rdat         : read-data stream, no backpressure
//   done, timeout_err        : one-cycle completion / abort pulses
//   wb_*                     : Wishbone initiator bus
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int unsigned AW      = 26,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            sdr_init_done,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic            wdat_valid,
  output logic            wdat_ready,
  input  logic [DW-1:0]   wdat,
  output logic            rdat_valid,
  output logic [DW-1:0]   rdat,
  output logic            done,
  output logic            timeout_err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int unsigned INC = byte_inc(DW);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic [2:0]        cti_q, cti_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic              rvld_q, rvld_d;
  logic [DW-1:0]     rdat_q, rdat_d;
  logic              ack;
  logic              last_beat;
  logic              expire;

  // Acks arriving while the strobe is low do not belong to any beat.
  assign ack       = wb_ack_i & stb_q;
  assign last_beat = (cnt_q == len_q);

  assign cmd_ready  = (state_q == ST_IDLE) & sdr_init_done;
  // The final ack must not pull in a beat that has no slot in this burst.
  assign wdat_ready = (state_q == ST_BURST) & we_q & (~stb_q | (ack & ~last_beat));

  wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (ack | ~cyc_q),
    .en_i     (stb_q & ~wb_ack_i),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    dat_d   = dat_q;
    cti_d   = cti_q;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    rvld_d  = ack & ~we_q;
    rdat_d  = (ack & ~we_q) ? wb_dat_i : rdat_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = ST_BURST;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 8'd0;
          cyc_d   = 1'b1;
          // Writes wait for their first data beat before strobing.
          stb_d   = ~cmd_we;
          cti_d   = cti_for(8'd0, cmd_len);
        end
      end
      ST_BURST: begin
        if (ack) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            done_d  = 1'b1;
            cti_d   = CTI_CLASSIC;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_q + AW'(INC);
            cti_d  = cti_for(cnt_q + 8'd1, len_q);
            if (we_q) begin
              // No pending beat: drop strobe, keep the cycle (wait state).
              stb_d = wdat_valid;
              if (wdat_valid) dat_d = wdat;
            end else begin
              stb_d = 1'b1;
            end
          end
        end else if (expire) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          terr_d  = 1'b1;
          cti_d   = CTI_CLASSIC;
        end else if (wdat_valid && wdat_ready) begin
          stb_d = 1'b1;
          dat_d = wdat;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sel_d = cyc_d ? '1 : '0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      cti_q   <= CTI_CLASSIC;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      cti_q   <= cti_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      rvld_q  <= rvld_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_addr_o   = addr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_cti_o    = cti_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign rdat_valid  = rvld_q;
  assign rdat        = rdat_q;

endmodule
